// File: rtl/johnson_phase_monitor.sv
// Phase decoder, sequence checker and lock tracker for a 6-bit twisted-ring counter.
// Optional build macro JPM_STALL_OK_EN: a repeated legal code is tolerated while locked.
module johnson_phase_monitor #(
   parameter int LOCK_COUNT = 3,
   parameter int REV_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sample_en,
   input  logic [5:0]       ring_q,
   input  logic             clear_err,
   output logic [3:0]       phase,
   output logic [11:0]      phase_onehot,
   output logic             valid,
   output logic             locked,
   output logic             wrap,
   output logic [REV_W-1:0] rev_count,
   output logic             illegal_err,
   output logic             step_err
);

   typedef enum logic [1:0] {SYNC, ACQUIRE, LOCKED, FAULT} state_t;

   localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);

   // {legal, phase}; phase is 0 for illegal codes
   function automatic logic [4:0] decode_code(input logic [5:0] c);
      case (c)
         6'b000000: decode_code = {1'b1, 4'd0};
         6'b100000: decode_code = {1'b1, 4'd1};
         6'b110000: decode_code = {1'b1, 4'd2};
         6'b111000: decode_code = {1'b1, 4'd3};
         6'b111100: decode_code = {1'b1, 4'd4};
         6'b111110: decode_code = {1'b1, 4'd5};
         6'b111111: decode_code = {1'b1, 4'd6};
         6'b011111: decode_code = {1'b1, 4'd7};
         6'b001111: decode_code = {1'b1, 4'd8};
         6'b000111: decode_code = {1'b1, 4'd9};
         6'b000011: decode_code = {1'b1, 4'd10};
         6'b000001: decode_code = {1'b1, 4'd11};
         default:   decode_code = 5'd0;
      endcase
   endfunction

   function automatic logic [5:0] succ_code(input logic [5:0] c);
      return {~c[0], c[5:1]};
   endfunction

   function automatic logic [11:0] onehot12(input logic [3:0] p);
      return 12'd1 << p;
   endfunction

   state_t     state, st_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic [5:0] prev_code;
   logic       prev_valid;

   logic [4:0] dec_cur;
   logic       cur_legal;
   logic [3:0] cur_phase;
   logic       in_seq;
   logic       stall;
   logic       set_ill, set_step, wrap_nxt, rev_inc;

   assign dec_cur   = decode_code(ring_q);
   assign cur_legal = dec_cur[4];
   assign cur_phase = dec_cur[3:0];
   assign in_seq    = prev_valid && (ring_q == succ_code(prev_code));

`ifdef JPM_STALL_OK_EN
   assign stall = prev_valid && cur_legal && (ring_q == prev_code);
`else
   assign stall = 1'b0;
`endif

   always_comb begin
      st_nxt   = state;
      cnt_nxt  = cnt;
      set_ill  = 1'b0;
      set_step = 1'b0;
      wrap_nxt = 1'b0;
      rev_inc  = 1'b0;
      if (sample_en) begin
         if (!cur_legal)
            set_ill = 1'b1;
         case (state)
            SYNC: begin
               if (cur_legal) begin
                  if (LOCK_CNT <= 4'd1) begin
                     st_nxt  = LOCKED;
                     cnt_nxt = 4'd0;
                  end else begin
                     st_nxt  = ACQUIRE;
                     cnt_nxt = 4'd1;
                  end
               end
            end
            ACQUIRE: begin
               if (!cur_legal) begin
                  st_nxt  = SYNC;
                  cnt_nxt = 4'd0;
               end else if (in_seq) begin
                  if (cnt + 4'd1 >= LOCK_CNT) begin
                     st_nxt  = LOCKED;
                     cnt_nxt = 4'd0;
                  end else begin
                     cnt_nxt = cnt + 4'd1;
                  end
               end else if (!stall) begin
                  cnt_nxt = 4'd1;
               end
            end
            LOCKED: begin
               if (!cur_legal) begin
                  st_nxt = FAULT;
               end else if (in_seq) begin
                  // a successor landing on phase 0 can only come from phase 11
                  if (cur_phase == 4'd0) begin
                     wrap_nxt = 1'b1;
                     rev_inc  = 1'b1;
                  end
               end else if (!stall) begin
                  set_step = 1'b1;
                  st_nxt   = FAULT;
               end
            end
            default: ;
         endcase
      end
      if (clear_err) begin
         st_nxt  = SYNC;
         cnt_nxt = 4'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= SYNC;
         cnt          <= 4'd0;
         prev_code    <= 6'd0;
         prev_valid   <= 1'b0;
         phase        <= 4'd0;
         phase_onehot <= 12'd0;
         valid        <= 1'b0;
         locked       <= 1'b0;
         wrap         <= 1'b0;
         rev_count    <= '0;
         illegal_err  <= 1'b0;
         step_err     <= 1'b0;
      end else begin
         state       <= st_nxt;
         cnt         <= cnt_nxt;
         locked      <= (st_nxt == LOCKED);
         wrap        <= wrap_nxt;
         illegal_err <= set_ill  | (illegal_err & ~clear_err);
         step_err    <= set_step | (step_err & ~clear_err);
         if (rev_inc)
            rev_count <= rev_count + REV_W'(1);
         if (sample_en) begin
            prev_code    <= ring_q;
            prev_valid   <= cur_legal;
            valid        <= cur_legal;
            phase_onehot <= cur_legal ? onehot12(cur_phase) : 12'd0;
            if (cur_legal)
               phase <= cur_phase;
         end
      end
   end

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Directed bench for johnson_phase_monitor: lock, wrap, errors, reset, counter rollover.
module tb_johnson_phase_monitor;

   logic        clk = 1'b0;
   logic        rst;
   logic        sample_en;
   logic [5:0]  ring_q;
   logic        clear_err;
   logic [3:0]  phase;
   logic [11:0] phase_onehot;
   logic        valid, locked, wrap, illegal_err, step_err;
   logic [7:0]  rev_count;

   int n_cmp = 0;
   int n_mis = 0;
   int cur_p;
   int exp_rev;
   logic [5:0] codes [12];

   johnson_phase_monitor #(.LOCK_COUNT(3), .REV_W(8)) dut (
      .clk(clk), .rst(rst), .sample_en(sample_en), .ring_q(ring_q),
      .clear_err(clear_err), .phase(phase), .phase_onehot(phase_onehot),
      .valid(valid), .locked(locked), .wrap(wrap), .rev_count(rev_count),
      .illegal_err(illegal_err), .step_err(step_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic samp(input logic [5:0] c, input logic en, input logic clr);
      @(negedge clk);
      ring_q    = c;
      sample_en = en;
      clear_err = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_phase"}, phase, 0);
      chk({tag, "_onehot"}, phase_onehot, 0);
      chk({tag, "_valid"}, valid, 0);
      chk({tag, "_locked"}, locked, 0);
      chk({tag, "_wrap"}, wrap, 0);
      chk({tag, "_rev"}, rev_count, 0);
      chk({tag, "_ill"}, illegal_err, 0);
      chk({tag, "_step"}, step_err, 0);
   endtask

   // advance a locked ring n steps, checking wrap and the revolution count
   task automatic adv(input int n);
      for (int i = 0; i < n; i++) begin
         cur_p = (cur_p + 1) % 12;
         samp(codes[cur_p], 1'b1, 1'b0);
         chk("adv_wrap", wrap, (cur_p == 0) ? 1 : 0);
         chk("adv_locked", locked, 1);
         if (cur_p == 0) begin
            exp_rev = (exp_rev + 1) % 256;
            chk("adv_rev", rev_count, exp_rev);
         end
      end
   endtask

   initial begin
      codes = '{6'b000000, 6'b100000, 6'b110000, 6'b111000, 6'b111100, 6'b111110,
                6'b111111, 6'b011111, 6'b001111, 6'b000111, 6'b000011, 6'b000001};
      rst = 1'b0; sample_en = 1'b1; ring_q = 6'b101010; clear_err = 1'b0;
      samp(6'b000000, 1'b1, 1'b0);
      samp(6'b100000, 1'b1, 1'b0);
      chk_zero("reset");
      rst = 1'b1;

      samp(6'b000000, 1'b1, 1'b0);
      chk("acq0_valid", valid, 1);
      chk("acq0_locked", locked, 0);
      samp(6'b100000, 1'b1, 1'b0);
      chk("acq1_locked", locked, 0);
      samp(6'b110000, 1'b1, 1'b0);
      chk("lock_locked", locked, 1);
      chk("lock_phase", phase, 2);
      chk("lock_onehot", phase_onehot, 12'h004);

      cur_p = 2; exp_rev = 0;
      adv(10);
      chk("wrap_pulse", wrap, 1);
      samp(6'b100000, 1'b0, 1'b0);
      chk("wrap_hold_clear", wrap, 0);
      chk("wrap_hold_rev", rev_count, 1);
      adv(2);
      chk("rev1", rev_count, 1);
      chk("rev1_ill", illegal_err, 0);
      chk("rev1_step", step_err, 0);

      samp(6'b101010, 1'b1, 1'b0);
      chk("illg_err", illegal_err, 1);
      chk("illg_valid", valid, 0);
      chk("illg_locked", locked, 0);
      chk("illg_phase", phase, 2);
      chk("illg_onehot", phase_onehot, 0);
      samp(6'b101010, 1'b0, 1'b1);
      chk("clr_ill", illegal_err, 0);
      chk("clr_locked", locked, 0);

      samp(6'b100000, 1'b1, 1'b0);
      samp(6'b110000, 1'b1, 1'b0);
      chk("relock_pre", locked, 0);
      samp(6'b111000, 1'b1, 1'b0);
      chk("relock", locked, 1);
      samp(6'b000111, 1'b0, 1'b0);
      chk("hold_phase", phase, 3);
      chk("hold_onehot", phase_onehot, 12'h008);
      chk("hold_locked", locked, 1);
      chk("hold_valid", valid, 1);
      chk("hold_step", step_err, 0);
      samp(6'b000111, 1'b1, 1'b0);
      chk("step_err", step_err, 1);
      chk("step_locked", locked, 0);
      chk("step_phase", phase, 9);
      chk("step_valid", valid, 1);
      samp(6'b000111, 1'b0, 1'b1);
      chk("clr_step", step_err, 0);

      samp(6'b110000, 1'b1, 1'b0);
      samp(6'b111000, 1'b1, 1'b0);
      samp(6'b111100, 1'b1, 1'b0);
      chk("lock4", locked, 1);
      samp(6'b111100, 1'b1, 1'b0);
`ifdef JPM_STALL_OK_EN
      chk("stall_locked", locked, 1);
      chk("stall_step", step_err, 0);
`else
      chk("repeat_step", step_err, 1);
      chk("repeat_locked", locked, 0);
`endif
      samp(6'b111100, 1'b0, 1'b1);
      chk("clr2_step", step_err, 0);

      samp(6'b000000, 1'b1, 1'b0);
      samp(6'b100000, 1'b1, 1'b0);
      samp(6'b110000, 1'b1, 1'b0);
      chk("lock5", locked, 1);
      cur_p = 2; exp_rev = 1;
      adv(48);
      chk("rev5", rev_count, 5);

      rst = 1'b0;
      samp(6'b111000, 1'b1, 1'b0);
      chk_zero("midrst");
      rst = 1'b1;

      samp(6'b000000, 1'b1, 1'b0);
      samp(6'b100000, 1'b1, 1'b0);
      samp(6'b110000, 1'b1, 1'b0);
      chk("lock6", locked, 1);
      cur_p = 2; exp_rev = 0;
      adv(255 * 12);
      chk("rev255", rev_count, 255);
      adv(12);
      chk("rev_roll", rev_count, 0);
      chk("final_ill", illegal_err, 0);
      chk("final_step", step_err, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
